// File: rtl/sel_seq_pkg.sv
// ============================================================================
// Module   : sel_seq_pkg
// Brief    : Shared state encoding and direction constants for sel_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sel_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : sel_seq_pkg

`default_nettype wire

// File: rtl/dwell_timer.sv
// ============================================================================
// Module   : dwell_timer
// Brief    : Dwell counter with synchronous clear, freeze (en low) and a
//            terminal-count flag raised while the count equals the limit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [DWELL_W-1:0] limit_i,
    output logic               tc_o
);

    localparam logic [DWELL_W-1:0] c_cnt_one = DWELL_W'(1);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // Clear wins over counting so a terminal cycle restarts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == limit_i);

endmodule : dwell_timer

`default_nettype wire

// File: rtl/sel_sequencer.sv
// ============================================================================
// Module   : sel_sequencer
// Brief    : Scans a decoder select code up or down, holding each code for a
//            programmable dwell, with pause, stop and direct load controls.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sel_sequencer
    import sel_seq_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int SEL_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               load,
    input  logic [SEL_W-1:0]   load_val,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               step,
    output logic               wrap
);

    localparam logic [SEL_W-1:0] c_sel_one = SEL_W'(1);
    localparam logic [SEL_W-1:0] c_sel_max = {SEL_W{1'b1}};

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               dir_q,   dir_d;
    logic               step_q,  step_d;
    logic               wrap_q,  wrap_d;

    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic               w_cnt_tc;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (w_cnt_clr),
        .en_i    (w_cnt_en),
        .limit_i (dwell_q),
        .tc_o    (w_cnt_tc)
    );

    // stop beats load beats start/pause. SCAN and HOLD both count on any
    // cycle with pause low, so a pause stretches the dwell by exactly its length.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        dwell_d   = dwell_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;

        if (stop) begin
            state_d   = IDLE;
            w_cnt_clr = 1'b1;
        end else if (load) begin
            sel_d     = load_val;
            w_cnt_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = SCAN;
                        dwell_d   = dwell;
                        dir_d     = dir;
                        w_cnt_clr = 1'b1;
                    end
                end
                SCAN, HOLD: begin
                    state_d = pause ? HOLD : SCAN;
                    if (!pause) begin
                        w_cnt_en = 1'b1;
                        if (w_cnt_tc) begin
                            w_cnt_clr = 1'b1;
                            step_d    = 1'b1;
                            if (dir_q == DIR_DOWN) begin
                                sel_d  = sel_q - c_sel_one;
                                wrap_d = (sel_q == '0);
                            end else begin
                                sel_d  = sel_q + c_sel_one;
                                wrap_d = (sel_q == c_sel_max);
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            dwell_q <= '0;
            dir_q   <= DIR_UP;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = (state_q != IDLE);
    assign step      = step_q;
    assign wrap      = wrap_q;

endmodule : sel_sequencer

`default_nettype wire

// File: tb/tb_sel_sequencer.sv
// ============================================================================
// Module   : tb_sel_sequencer
// Brief    : Directed scenarios plus randomized traffic for sel_sequencer,
//            scored against a cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sel_sequencer;

    localparam int DWELL_W = 8;
    localparam int SEL_W   = 2;
    localparam int NSEL    = 1 << SEL_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic               pause;
    logic               load;
    logic [SEL_W-1:0]   load_val;
    logic               dir;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               step;
    logic               wrap;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: values the DUT should present after the most recent edge.
    int m_active, m_elapsed, m_sel, m_dwell, m_dir, m_step, m_wrap;

    sel_sequencer #(
        .DWELL_W (DWELL_W),
        .SEL_W   (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .load      (load),
        .load_val  (load_val),
        .dir       (dir),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .step      (step),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active  = 0;
        m_elapsed = 0;
        m_sel     = 0;
        m_dwell   = 0;
        m_dir     = 0;
        m_step    = 0;
        m_wrap    = 0;
    endtask

    task automatic model_step();
        m_step = 0;
        m_wrap = 0;
        if (!rst_n) begin
            model_reset();
        end else if (stop) begin
            m_active  = 0;
            m_elapsed = 0;
        end else if (load) begin
            m_sel     = int'(load_val);
            m_elapsed = 0;
        end else if (m_active == 0) begin
            if (start) begin
                m_active  = 1;
                m_elapsed = 0;
                m_dwell   = int'(dwell);
                m_dir     = int'(dir);
            end
        end else if (!pause) begin
            if (m_elapsed == m_dwell) begin
                m_step    = 1;
                m_elapsed = 0;
                if (m_dir == 0) begin
                    m_wrap = (m_sel == NSEL - 1) ? 1 : 0;
                    m_sel  = (m_sel + 1) % NSEL;
                end else begin
                    m_wrap = (m_sel == 0) ? 1 : 0;
                    m_sel  = (m_sel + NSEL - 1) % NSEL;
                end
            end else begin
                m_elapsed++;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("sel",       32'(sel),       32'(m_sel));
        check("sel_valid", 32'(sel_valid), 32'(m_active));
        check("step",      32'(step),      32'(m_step));
        check("wrap",      32'(wrap),      32'(m_wrap));
        start = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;
    endtask

    // Reset lands mid-cycle; outputs must clear before any clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_sel",   32'(sel),       32'(0));
        check("arst_valid", 32'(sel_valid), 32'(0));
        check("arst_step",  32'(step),      32'(0));
        check("arst_wrap",  32'(wrap),      32'(0));
        @(posedge clk);
        #1;
        check("arst_hold_sel", 32'(sel), 32'(0));
        rst_n = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;
    endtask

    initial begin
        int n;
        int wraps;
        int found;
        int saved;
        int seq [5] = '{3, 2, 1, 0, 3};

        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        pause    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        dir      = 1'b0;
        dwell    = '0;
        model_reset();

        #2;
        check("rst_sel",   32'(sel),       32'(0));
        check("rst_valid", 32'(sel_valid), 32'(0));
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();

        // Up scan, dwell 3: each code held 4 cycles, single wrap 3->0.
        dwell = 8'd3;
        dir   = 1'b0;
        start = 1'b1;
        cycle();
        check("s33_valid", 32'(sel_valid), 32'(1));
        wraps = 0;
        for (int i = 0; i < 17; i++) begin
            cycle();
            if (wrap) wraps++;
            if (i == 2)  check("s33_sel0", 32'(sel), 32'(0));
            if (i == 3)  check("s33_sel1", 32'(sel), 32'(1));
            if (i == 15) check("s33_sel0b", 32'(sel), 32'(0));
        end
        check("s33_wraps", 32'(wraps), 32'(1));

        // Down scan, dwell 0: step every cycle.
        stop = 1'b1;
        cycle();
        load     = 1'b1;
        load_val = 2'd0;
        cycle();
        dwell = 8'd0;
        dir   = 1'b1;
        start = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("s34_sel",  32'(sel),  32'(seq[i]));
            check("s34_step", 32'(step), 32'(1));
            check("s34_wrap", 32'(wrap), 32'(i == 0 || i == 4));
        end

        // Pause at count 2 with dwell 5: frozen, then 3 increments plus the terminal cycle.
        stop = 1'b1;
        cycle();
        load     = 1'b1;
        load_val = 2'd0;
        cycle();
        dwell = 8'd5;
        dir   = 1'b0;
        start = 1'b1;
        cycle();
        cycle();
        cycle();
        pause = 1'b1;
        dwell = 8'd1;
        dir   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("s35_frozen", 32'(sel), 32'(0));
        end
        pause = 1'b0;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (step) begin
                n = i;
                break;
            end
        end
        check("s35_latency", 32'(n), 32'(5 - 2 + 1));
        check("s35_sel", 32'(sel), 32'(1));

        // Load on the cycle an advance is due: load wins, no step.
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_active != 0 && m_elapsed == m_dwell) begin
                found = 1;
                break;
            end
            cycle();
        end
        check("s36_found", 32'(found), 32'(1));
        load     = 1'b1;
        load_val = 2'd2;
        cycle();
        check("s36_sel",  32'(sel),  32'(2));
        check("s36_step", 32'(step), 32'(0));
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (step) begin
                n = i;
                break;
            end
        end
        check("s36_latency", 32'(n), 32'(6));

        // stop and load together: stop wins, sel untouched.
        cycle();
        saved    = m_sel;
        stop     = 1'b1;
        load     = 1'b1;
        load_val = SEL_W'((saved + 1) % NSEL);
        cycle();
        check("s37_sel",   32'(sel),       32'(saved));
        check("s37_valid", 32'(sel_valid), 32'(0));

        // Asynchronous reset mid-scan at sel 3, then restart from 0.
        dwell = 8'd5;
        dir   = 1'b0;
        start = 1'b1;
        cycle();
        load     = 1'b1;
        load_val = 2'd3;
        cycle();
        cycle();
        check("s38_pre", 32'(sel), 32'(3));
        async_reset();
        start = 1'b1;
        cycle();
        check("s38_resume", 32'(sel), 32'(0));
        check("s38_valid",  32'(sel_valid), 32'(1));
        repeat (6) cycle();
        check("s38_adv", 32'(sel), 32'(1));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 29) == 0);
            load     = ($urandom_range(0, 19) == 0);
            load_val = SEL_W'($urandom_range(0, NSEL - 1));
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            if ($urandom_range(0, 9) == 0) dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                dwell = ($urandom_range(0, 9) == 0) ? 8'd12 : DWELL_W'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sel_sequencer

`default_nettype wire
